// File: rtl/grf_pkg.sv
// Shared constants and trace-entry type for the writeback register file.
package grf_pkg;

  localparam int unsigned GRF_NUM     = 32;
  localparam logic [4:0]  ZERO_REG    = 5'd0;
  localparam logic [4:0]  RA_REG      = 5'd31;
  localparam int unsigned TRACE_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/grf_trace_fifo.sv
// Write-trace FIFO: registered valid/ready output, drop-on-full with sticky overflow.
module grf_trace_fifo
  import grf_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  trace_entry_t entry_i,
  output logic         valid_o,
  input  logic         ready_i,
  output trace_entry_t entry_o,
  output logic         overflow_o
);

  localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW = $clog2(TRACE_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(TRACE_DEPTH);

  trace_entry_t          mem_q [TRACE_DEPTH];
  trace_entry_t          mem_d [TRACE_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, push_ok;

  assign valid_o    = (count_q != '0);
  assign entry_o    = valid_o ? mem_q[rptr_q] : '0;
  assign overflow_o = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = valid_o && ready_i;
    // A full FIFO still accepts a push when the oldest entry leaves on the same edge.
    push_ok    = push_i && ((count_q != CntFull) || pop);
    if (push_ok) begin
      mem_d[wptr_q] = entry_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    if (push_i && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/grf_wb.sv
// 32x32 register file written from writeback, with a write-trace stream.
// Define GRF_WB_BYPASS_EN for write-first forwarding of WD onto RD1/RD2.
module grf_wb
  import grf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic        WE,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  logic [31:0]  regs_q [GRF_NUM];
  logic [31:0]  regs_d [GRF_NUM];
  logic         wr_en;
  trace_entry_t push_entry, head_entry;

  assign wr_en = WE && (A3 != ZERO_REG);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[A3] = WD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GRF_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // $0 is never written, so regs_q[0] stays zero; the guard keeps it explicit.
  always_comb begin
    RD1 = (A1 == ZERO_REG) ? '0 : regs_q[A1];
    RD2 = (A2 == ZERO_REG) ? '0 : regs_q[A2];
`ifdef GRF_WB_BYPASS_EN
    if (wr_en && (A3 == A1)) begin
      RD1 = WD;
    end
    if (wr_en && (A3 == A2)) begin
      RD2 = WD;
    end
`endif
  end

  assign push_entry = '{pc: PC, addr: A3, data: WD};

  grf_trace_fifo u_trace_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_i     (wr_en),
    .entry_i    (push_entry),
    .valid_o    (trace_valid),
    .ready_i    (trace_ready),
    .entry_o    (head_entry),
    .overflow_o (trace_overflow)
  );

  assign trace_pc   = head_entry.pc;
  assign trace_addr = head_entry.addr;
  assign trace_data = head_entry.data;

endmodule

// File: tb/tb_grf_wb.sv
// Directed self-checking bench for grf_wb.
module tb_grf_wb;

  logic        clk, reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] RD1, RD2, WD, PC;
  logic        WE;
  logic        trace_valid, trace_ready, trace_overflow;
  logic [31:0] trace_pc, trace_data;
  logic [4:0]  trace_addr;

  int n_tests = 0;
  int n_fail  = 0;

  grf_wb dut (
    .clk            (clk),
    .reset          (reset),
    .A1             (A1),
    .A2             (A2),
    .RD1            (RD1),
    .RD2            (RD2),
    .WE             (WE),
    .A3             (A3),
    .WD             (WD),
    .PC             (PC),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    @(negedge clk);
    WE = 1'b1; A3 = a; WD = d; PC = pc;
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  task automatic check_head(input string name, input logic v, input logic [31:0] pc,
                            input logic [4:0] a, input logic [31:0] d);
    n_tests++;
    if (trace_valid !== v || (v && (trace_pc !== pc || trace_addr !== a || trace_data !== d))) begin
      n_fail++;
      $display("FAIL %s: got v=%b {%h,%0d,%h} want v=%b {%h,%0d,%h}", name, trace_valid,
               trace_pc, trace_addr, trace_data, v, pc, a, d);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (trace_valid !== 1'b0 || trace_overflow !== 1'b0 || trace_pc !== 32'h0 ||
        trace_addr !== 5'd0 || trace_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_trace: v=%b ov=%b pc=%h a=%0d d=%h want all 0", trace_valid,
               trace_overflow, trace_pc, trace_addr, trace_data);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      #1;
      n_tests++;
      if (RD1 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rd1[%0d]: got %h want 0", i, RD1);
      end
    end
    n_tests++;
    if (trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: v=%b ov=%b want 0 0", trace_valid, trace_overflow);
    end
  endtask

  task automatic test_write_ra();
    trace_ready = 1'b0;
    write_reg(5'd31, 32'h0000_3008, 32'h0000_3000);
    @(negedge clk);
    A1 = 5'd31; A2 = 5'd31;
    #1;
    n_tests++;
    if (RD1 !== 32'h0000_3008 || RD2 !== 32'h0000_3008) begin
      n_fail++;
      $display("FAIL write_ra_rd: RD1=%h RD2=%h want 00003008", RD1, RD2);
    end
    check_head("write_ra_trace", 1'b1, 32'h0000_3000, 5'd31, 32'h0000_3008);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
    check_head("write_ra_popped", 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_zero_write();
    write_reg(5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
    @(negedge clk);
    A1 = 5'd0;
    #1;
    n_tests++;
    if (RD1 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_write_rd: got %h want 0", RD1);
    end
    check_head("zero_write_trace", 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_overflow();
    trace_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      write_reg(5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
    end
    @(negedge clk);
    n_tests++;
    if (trace_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b want 1", trace_overflow);
    end
    check_head("overflow_hold0", 1'b1, 32'h4004, 5'd1, 32'h101);
    @(negedge clk);
    check_head("overflow_hold1", 1'b1, 32'h4004, 5'd1, 32'h101);
    for (int i = 1; i <= 4; i++) begin
      check_head("overflow_drain", 1'b1, 32'h4000 + 32'(4 * i), 5'(i), 32'h100 + 32'(i));
      trace_ready = 1'b1;
      @(negedge clk);
    end
    trace_ready = 1'b0;
    check_head("overflow_empty", 1'b0, 32'h0, 5'd0, 32'h0);
    n_tests++;
    if (trace_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b want 1", trace_overflow);
    end
  endtask

  task automatic test_same_cycle_read();
    do_reset();
    trace_ready = 1'b1;
    write_reg(5'd8, 32'h5, 32'h5000);
    @(negedge clk);
    WE = 1'b1; A3 = 5'd8; WD = 32'h1234; PC = 32'h5004; A1 = 5'd8;
    #1;
    n_tests++;
`ifdef GRF_WB_BYPASS_EN
    if (RD1 !== 32'h1234) begin
      n_fail++;
      $display("FAIL same_cycle_rd: got %h want 00001234", RD1);
    end
`else
    if (RD1 !== 32'h5) begin
      n_fail++;
      $display("FAIL same_cycle_rd: got %h want 00000005", RD1);
    end
`endif
    @(posedge clk);
    #1 WE = 1'b0;
    @(negedge clk);
    n_tests++;
    if (RD1 !== 32'h1234) begin
      n_fail++;
      $display("FAIL same_cycle_after: got %h want 00001234", RD1);
    end
    trace_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      write_reg(5'(i), 32'hA00 + 32'(i), 32'h6000 + 32'(i));
    end
    @(negedge clk);
    WE = 1'b1; A3 = 5'd14; WD = 32'hA0E; PC = 32'h600E; trace_ready = 1'b1;
    @(posedge clk);
    #1 WE = 1'b0; trace_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (trace_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop_ov: got %b want 0", trace_overflow);
    end
    for (int i = 11; i <= 14; i++) begin
      check_head("full_pushpop_drain", 1'b1, 32'h6000 + 32'(i), 5'(i), 32'hA00 + 32'(i));
      trace_ready = 1'b1;
      @(negedge clk);
    end
    trace_ready = 1'b0;
    check_head("full_pushpop_empty", 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    WE = 1'b1; A3 = 5'd5; WD = 32'hDEAD_BEEF; PC = 32'h7000;
    #2 reset = 1'b0;
    @(negedge clk);
    WE = 1'b0;
    reset = 1'b1;
    A1 = 5'd5; A2 = 5'd14;
    #1;
    n_tests++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_write_rd: RD1=%h RD2=%h want 0 0", RD1, RD2);
    end
    check_head("mid_write_trace", 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; PC = '0;
    trace_ready = 1'b0;
    test_reset();
    test_write_ra();
    test_zero_write();
    test_overflow();
    test_same_cycle_read();
    test_full_push_pop();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wb.md
GRF_WB -- requirements
Module: grf_wb

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports A1, A2, inputs, 5 bits each: read register addresses (rs, rt).
REQ-004 SHALL have ports RD1, RD2, outputs, 32 bits each: read data for A1, A2.
REQ-005 SHALL have port WE, input, 1 bit: write enable from the writeback stage.
REQ-006 SHALL have port A3, input, 5 bits: write address (the RegAddr selected from rt/rd/$31).
REQ-007 SHALL have port WD, input, 32 bits: write data (the RegData selected from result/ReadData/PCLink/less).
REQ-008 SHALL have port PC, input, 32 bits: PC of the instruction doing the write, used for the trace only.
REQ-009 SHALL have ports trace_valid (output, 1), trace_ready (input, 1), trace_pc (output, 32), trace_addr (output, 5), trace_data (output, 32): write-trace stream.
REQ-010 SHALL have port trace_overflow, output, 1 bit: sticky flag for a dropped trace entry.

Function
REQ-011 SHALL hold 32 registers of 32 bits; $0 reads 0 at all times.
REQ-012 SHALL write WD into register A3 on a rising clk edge when WE=1 and A3!=0.
REQ-013 SHALL ignore writes with A3=0; no register change, no trace entry.
REQ-014 SHALL drive RD1/RD2 combinationally from A1/A2, with zero-cycle latency.
REQ-015 SHALL push one trace entry {PC, A3, WD} into a 4-deep FIFO for every write accepted under REQ-012.
REQ-016 SHALL assert trace_valid whenever the FIFO is non-empty, with trace_pc/addr/data showing the oldest entry.
REQ-017 SHALL pop the oldest entry on an edge where trace_valid=1 and trace_ready=1.
REQ-018 SHALL hold trace outputs stable while trace_valid=1 and trace_ready=0.
REQ-019 SHALL, on a push when the FIFO is full and no pop occurs, drop the new entry, keep the stored entries, and set trace_overflow=1 until reset.
REQ-020 SHALL, on a push and pop in the same cycle while full, perform both; count stays 4 and no overflow is flagged.
REQ-021 SHALL, on a push and pop in the same cycle while empty, store the new entry with count 1; no combinational pass-through to the trace outputs.
REQ-022 SHALL wrap the FIFO read/write pointers modulo 4.

Reset
REQ-023 SHALL, while reset=0 regardless of clk, clear all 32 registers, empty the FIFO (trace_valid=0), and clear trace_overflow.
REQ-024 SHALL, when reset is asserted mid-write, complete no write; on reset release all registers read 0.
REQ-025 SHALL drive trace_pc, trace_addr and trace_data to 0 during reset.

Configuration
REQ-026 SHALL define macro GRF_WB_BYPASS_EN.
REQ-027 SHALL, with GRF_WB_BYPASS_EN defined, drive RD1 (RD2) with WD when WE=1, A3!=0 and A3==A1 (A2): write-first forwarding.
REQ-028 SHALL, without GRF_WB_BYPASS_EN, return the pre-edge stored value for a same-cycle read of A3.

Structure
REQ-029 SHALL take constants from shared package grf_pkg: GRF_NUM=32, ZERO_REG=5'd0, RA_REG=5'd31, TRACE_DEPTH=4, and the trace-entry typedef {pc[31:0], addr[4:0], data[31:0]}.
REQ-030 SHALL place the trace buffer in sub-module grf_trace_fifo (valid/ready, sticky overflow); the register array stays in grf_wb.

Verification
REQ-031 SHALL cover: reset=0 then release; read all A1 0..31 -> RD1=0, trace_valid=0, trace_overflow=0.
REQ-032 SHALL cover: WE=1, A3=31, WD=32'h0000_3008, PC=32'h0000_3000 -> next cycle RD1(A1=31)=32'h3008; trace entry {3000,31,3008}.
REQ-033 SHALL cover: WE=1, A3=0, WD=32'hFFFF_FFFF -> RD1(A1=0)=0 and no trace entry.
REQ-034 SHALL cover: trace_ready=0, 5 writes to $1..$5 -> entries $1..$4 kept, $5 dropped, trace_overflow=1; then ready=1 -> entries $1,$2,$3,$4 drained in order.
REQ-035 SHALL cover: same-cycle WE=1, A3=A1=8, WD=32'h1234 over old value 32'h5 -> RD1=32'h1234 with GRF_WB_BYPASS_EN, 32'h5 without.
REQ-036 SHALL cover: FIFO full, push and pop on the same edge -> count stays 4, trace_overflow unchanged.
